sid_bus_ctrl: RTL

SID_BUS_CTRL -- requirements
Module: sid_bus_ctrl

---
 rtl/sid_pkg.sv | 24 ++
 rtl/sid_wr_fifo.sv | 91 +++++++++
 rtl/sid_bus_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared types and constants for the SID bus controller.
package sid_pkg;
  localparam int DIV_BITS        = 3;
  localparam int RES_PHI2_CYCLES = 16;
  localparam int WR_FIFO_DEPTH   = 4;
  localparam int ADDR_W          = 5;
  localparam int DATA_W          = 8;

  localparam int RES_CLKS  = RES_PHI2_CYCLES * (1 << DIV_BITS);
  localparam int RES_CNT_W = $clog2(RES_CLKS);

  typedef enum logic [2:0] {
    RESET,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } sid_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sid_wr_t;
endpackage

// File: rtl/sid_wr_fifo.sv
// Write queue for the SID bus: 4-entry ring buffer with SID_WR_FIFO_EN,
// otherwise a single holding register. full_nxt/empty_nxt let the parent register its flags.
module sid_wr_fifo
  import sid_pkg::*;
(
  input  logic    gclk,
  input  logic    grst_n,
  input  logic    flush,
  input  logic    push,
  input  logic    pop,
  input  sid_wr_t wdata,
  output sid_wr_t rdata,
  output logic    full,
  output logic    empty,
  output logic    full_nxt,
  output logic    empty_nxt
);
  logic push_ok, pop_ok;

  // A push on a full queue is refused even when a pop happens in the same clock.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

`ifdef SID_WR_FIFO_EN
  localparam int PTR_W = $clog2(WR_FIFO_DEPTH);

  sid_wr_t          mem [WR_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (flush) cnt_nxt = '0;
    else       cnt_nxt = cnt + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata     = mem[rd_ptr];
  assign full      = (cnt == (PTR_W+1)'(WR_FIFO_DEPTH));
  assign empty     = (cnt == '0);
  assign full_nxt  = (cnt_nxt == (PTR_W+1)'(WR_FIFO_DEPTH));
  assign empty_nxt = (cnt_nxt == '0);
`else
  sid_wr_t hold_q;
  logic    vld_q, vld_nxt;

  always_comb begin
    vld_nxt = vld_q;
    if (flush)        vld_nxt = 1'b0;
    else if (push_ok) vld_nxt = 1'b1;
    else if (pop_ok)  vld_nxt = 1'b0;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q <= vld_nxt;
      if (push_ok) hold_q <= wdata;
    end
  end

  assign rdata     = hold_q;
  assign full      = vld_q;
  assign empty     = !vld_q;
  assign full_nxt  = vld_nxt;
  assign empty_nxt = !vld_nxt;
`endif
endmodule

// File: rtl/sid_bus_ctrl.sv
// SID bus controller: phi2 divider, reset sequencer and write strobe FSM.
// Queue depth is selected by SID_WR_FIFO_EN (see sid_wr_fifo).
module sid_bus_ctrl
  import sid_pkg::*;
(
  input  logic              C6_CLK_8MHZ,
  input  logic              C6_RST_N,
  input  logic              SOFT_RES,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY,
  output logic              SID_CLK,
  output logic              SID_CS,
  output logic              SID_RES,
  output logic [ADDR_W-1:0] SID_ADDR,
  output logic [DATA_W-1:0] SID_DATA
);
  localparam logic [DIV_BITS-1:0] DIV_MID = {1'b0, {(DIV_BITS-1){1'b1}}};

  logic [DIV_BITS-1:0]  div_cnt;
  logic [RES_CNT_W-1:0] rst_cnt;
  sid_state_e           state, state_nxt;

  logic    div_last, div_mid;
  logic    q_push, q_pop, q_full, q_empty, q_full_nxt, q_empty_nxt;
  sid_wr_t q_wdata, q_rdata;

  assign div_last = (div_cnt == '1);
  assign div_mid  = (div_cnt == DIV_MID);
  assign SID_CLK  = div_cnt[DIV_BITS-1];

  assign q_push  = WR_VALID && WR_READY;
  assign q_pop   = (state == IDLE) && !q_empty && div_last && !SOFT_RES;
  assign q_wdata = '{addr: WR_ADDR, data: WR_DATA};

  sid_wr_fifo u_wr_fifo (
    .gclk      (C6_CLK_8MHZ),
    .grst_n    (C6_RST_N),
    .flush     (SOFT_RES),
    .push      (q_push),
    .pop       (q_pop),
    .wdata     (q_wdata),
    .rdata     (q_rdata),
    .full      (q_full),
    .empty     (q_empty),
    .full_nxt  (q_full_nxt),
    .empty_nxt (q_empty_nxt)
  );

  // phi2 runs freely; soft reset must not disturb it.
  always_ff @(posedge C6_CLK_8MHZ or negedge C6_RST_N) begin
    if (!C6_RST_N) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_BITS'(1);
  end

  always_ff @(posedge C6_CLK_8MHZ or negedge C6_RST_N) begin
    if (!C6_RST_N) begin
      state   <= RESET;
      rst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (SOFT_RES || state != RESET) rst_cnt <= '0;
      else                            rst_cnt <= rst_cnt + RES_CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (SOFT_RES) begin
      state_nxt = RESET;
    end else begin
      case (state)
        RESET:   if (rst_cnt == RES_CNT_W'(RES_CLKS-1)) state_nxt = IDLE;
        IDLE:    if (!q_empty && div_last) state_nxt = SETUP;
        SETUP:   if (div_mid) state_nxt = STROBE;
        STROBE:  if (div_last) state_nxt = HOLD;
        HOLD:    state_nxt = IDLE;
        default: state_nxt = RESET;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge C6_CLK_8MHZ or negedge C6_RST_N) begin
    if (!C6_RST_N) begin
      SID_CS   <= 1'b1;
      SID_RES  <= 1'b0;
      WR_READY <= 1'b0;
      BUSY     <= 1'b1;
      SID_ADDR <= '0;
      SID_DATA <= '0;
    end else begin
      SID_CS   <= (state_nxt != STROBE);
      SID_RES  <= (state_nxt != RESET);
      WR_READY <= (state_nxt != RESET) && !q_full_nxt;
      BUSY     <= (state_nxt != IDLE) || !q_empty_nxt;
      if (q_pop) begin
        SID_ADDR <= q_rdata.addr;
        SID_DATA <= q_rdata.data;
      end
    end
  end
endmodule
